crc_serial_engine: RTL and testbench

//   Bit-serial, runtime-configurable CRC core. Sits directly downstream of the decelerator top FSM.

---
 rtl/crc_serial_engine.sv | 89 ++++++++
 tb/tb_crc_serial_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_engine.sv
// Bit-serial runtime-configurable CRC engine (width 1..W, arbitrary poly/init/xor, reflect in/out).
// Latency: one message bit per shift cycle; crc is combinational from the remainder register.
// Backpressure: none; the upstream FSM paces bits with shift and reads crc whenever it needs to.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   initialize             load remainder from init_value (masked to N bits); wins over shift
//   shift                  consume data[bit_index] (or data[7-bit_index]) this cycle
//   reflect_in/out         LSB-first data bit order / bit-reverse remainder over N bits
//   bitwidth               N-1, where N is the active CRC width
//   bit_index, data        current message byte and which bit of it to consume
//   poly, init_value,      generator (implicit top bit omitted), initial remainder, final xor;
//   xor_out                bits at or above N are ignored
//   crc                    finalised CRC, zero above bit N-1
//   byte_done              one-cycle pulse the cycle after a bit_index==7 shift
module crc_serial_engine #(
    parameter int W     = 32,
    parameter int WBITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             initialize,
    input  logic             shift,
    input  logic             reflect_in,
    input  logic             reflect_out,
    input  logic [WBITS-1:0] bitwidth,
    input  logic [2:0]       bit_index,
    input  logic [7:0]       data,
    input  logic [W-1:0]     poly,
    input  logic [W-1:0]     init_value,
    input  logic [W-1:0]     xor_out,
    output logic [W-1:0]     crc,
    output logic             byte_done
);

    logic [W-1:0]     rem;
    logic [W-1:0]     mask;
    logic [W-1:0]     rem_next;
    logic [W-1:0]     rem_refl;
    logic [WBITS-1:0] refl_idx;
    logic             din;
    logic             fb;

    // Ones in bits [bitwidth:0]. W == 2**WBITS, so the cast index never wraps.
    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (WBITS'(i) <= bitwidth);
        end
    end

    // ~bit_index on a 3-bit value is 7-bit_index (MSB-first order).
    always_comb begin
        din      = reflect_in ? data[bit_index] : data[~bit_index];
        fb       = rem[bitwidth] ^ din;
        // The bit shifted out of position N-1 is dropped by the mask.
        rem_next = ({rem[W-2:0], 1'b0} ^ (fb ? poly : '0)) & mask;
    end

    // Reflection pivots around the active width, not around W.
    always_comb begin
        rem_refl = '0;
        refl_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (WBITS'(i) <= bitwidth) begin
                refl_idx    = bitwidth - WBITS'(i);
                rem_refl[i] = reflect_out ? rem[refl_idx] : rem[i];
            end
        end
    end

    assign crc = (rem_refl ^ xor_out) & mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            byte_done <= 1'b0;
        end else if (initialize) begin
            rem       <= init_value & mask;
            byte_done <= 1'b0;
        end else if (shift) begin
            rem       <= rem_next;
            byte_done <= (bit_index == 3'd7);
        end else begin
            byte_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc_serial_engine.sv
module tb_crc_serial_engine;

    logic        clk;
    logic        rst;
    logic        initialize;
    logic        shift;
    logic        reflect_in;
    logic        reflect_out;
    logic [4:0]  bitwidth;
    logic [2:0]  bit_index;
    logic [7:0]  data;
    logic [31:0] poly;
    logic [31:0] init_value;
    logic [31:0] xor_out;
    logic [31:0] crc;
    logic        byte_done;

    int tests_run = 0;
    int tests_failed = 0;
    int bd_count = 0;
    bit chk_en = 0;

    // Behavioural model state
    logic [31:0] m_rem;
    logic        m_bd;

    logic [7:0]  msg [16];
    int          msg_len;

    crc_serial_engine #(.W(32), .WBITS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .initialize  (initialize),
        .shift       (shift),
        .reflect_in  (reflect_in),
        .reflect_out (reflect_out),
        .bitwidth    (bitwidth),
        .bit_index   (bit_index),
        .data        (data),
        .poly        (poly),
        .init_value  (init_value),
        .xor_out     (xor_out),
        .crc         (crc),
        .byte_done   (byte_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mask_of(input int n);
        if (n >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << n) - 32'h1;
    endfunction

    function automatic logic [31:0] rev_n(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) if (v[i]) r[n-1-i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] finalize(input logic [31:0] r, input int n,
                                             input logic ro, input logic [31:0] xr);
        return ((ro ? rev_n(r, n) : r) ^ xr) & mask_of(n);
    endfunction

    // Whole-message reference: classic MSB-first long division, reflected input
    // handled by reversing each byte up front.
    function automatic logic [31:0] crc_of(input int len, input int n, input logic [31:0] p,
                                           input logic [31:0] ini, input logic [31:0] xr,
                                           input logic ri, input logic ro);
        logic [31:0] r;
        logic [7:0]  b;
        logic        top;
        r = ini & mask_of(n);
        for (int k = 0; k < len; k++) begin
            b = ri ? rev_n({24'h0, msg[k]}, 8) : msg[k];
            for (int j = 7; j >= 0; j--) begin
                top = r[n-1] ^ b[j];
                r = ((r << 1) ^ (top ? p : 32'h0)) & mask_of(n);
            end
        end
        return finalize(r, n, ro, xr);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // Cycle-level model of the register update rules.
    always @(posedge clk) begin
        int          n;
        logic        din;
        logic        fb;
        n = int'(bitwidth) + 1;
        if (rst) begin
            m_rem = '0;
            m_bd  = 1'b0;
        end else if (initialize) begin
            m_rem = init_value & mask_of(n);
            m_bd  = 1'b0;
        end else if (shift) begin
            din   = reflect_in ? data[bit_index] : data[7 - int'(bit_index)];
            fb    = m_rem[n-1] ^ din;
            m_rem = ((m_rem << 1) ^ (fb ? poly : 32'h0)) & mask_of(n);
            m_bd  = (bit_index == 3'd7);
        end else begin
            m_bd  = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("crc_cycle", crc, finalize(m_rem, int'(bitwidth) + 1, reflect_out, xor_out));
            check("byte_done_cycle", {31'h0, byte_done}, {31'h0, m_bd});
            if (byte_done) bd_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_shift(input logic [7:0] d, input logic [2:0] bi);
        data      = d;
        bit_index = bi;
        shift     = 1'b1;
        tick();
        shift     = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] d);
        for (int bi = 0; bi < 8; bi++) do_shift(d, 3'(bi));
    endtask

    task automatic feed_digits();
        for (int k = 0; k < 9; k++) feed_byte(8'h31 + 8'(k));
    endtask

    task automatic do_init();
        initialize = 1'b1;
        tick();
        initialize = 1'b0;
    endtask

    task automatic setcfg(input logic [4:0] bw, input logic [31:0] p, input logic [31:0] ini,
                          input logic [31:0] xr, input logic ri, input logic ro);
        bitwidth    = bw;
        poly        = p;
        init_value  = ini;
        xor_out     = xr;
        reflect_in  = ri;
        reflect_out = ro;
    endtask

    initial begin
        rst = 1'b1; initialize = 1'b0; shift = 1'b0;
        bit_index = '0; data = '0;
        setcfg(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick();
        chk_en = 1;
        tick();
        check("reset_crc", crc, 32'hFFFF_FFFF);
        check("reset_byte_done", {31'h0, byte_done}, 32'h0);
        rst = 1'b0;

        // Pin the whole-message reference to known catalogue values.
        for (int k = 0; k < 9; k++) msg[k] = 8'h31 + 8'(k);
        check("model_crc32", crc_of(9, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1), 32'hCBF4_3926);
        check("model_ccitt", crc_of(9, 16, 32'h1021, 32'hFFFF, 32'h0, 0, 0), 32'h0000_29B1);

        // CRC-32
        do_init();
        bd_count = 0;
        feed_digits();
        check("crc32", crc, 32'hCBF4_3926);
        check("crc32_byte_done_last", {31'h0, byte_done}, 32'h1);
        tick();
        check("crc32_byte_done_count", bd_count, 9);

        // CRC-16/CCITT-FALSE, upper half must stay clear every step
        setcfg(5'd15, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
        do_init();
        for (int k = 0; k < 9; k++) begin
            feed_byte(8'h31 + 8'(k));
            check("ccitt_upper_zero", {16'h0, crc[31:16]}, 32'h0);
        end
        check("ccitt", crc, 32'h0000_29B1);

        // CRC-8, then re-initialize
        setcfg(5'd7, 32'h07, 32'h00, 32'h00, 1'b0, 1'b0);
        do_init();
        feed_digits();
        check("crc8", crc, 32'h0000_00F4);
        do_init();
        check("crc8_reinit", crc, 32'h0);

        // Reset mid-byte
        setcfg(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_init();
        for (int bi = 0; bi < 3; bi++) do_shift(8'h31, 3'(bi));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_crc", crc, 32'hFFFF_FFFF);
        check("midreset_byte_done", {31'h0, byte_done}, 32'h0);
        do_init();
        feed_digits();
        check("crc32_rerun", crc, 32'hCBF4_3926);

        // Collision of initialize and shift, then idle hold
        setcfg(5'd31, 32'h04C1_1DB7, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        data = 8'hFF; bit_index = 3'd7;
        initialize = 1'b1; shift = 1'b1;
        tick();
        initialize = 1'b0; shift = 1'b0;
        check("collision_crc", crc, 32'h1234_5678);
        check("collision_byte_done", {31'h0, byte_done}, 32'h0);
        repeat (5) tick();
        check("idle_hold", crc, 32'h1234_5678);

        // Upper config bits ignored
        setcfg(5'd7, 32'hFFFF_FF07, 32'hFFFF_FF00, 32'h0, 1'b0, 1'b0);
        do_init();
        check("mask_init", crc, 32'h0);
        feed_digits();
        check("mask_crc8", crc, 32'h0000_00F4);

        // Width-1 CRC: parity of all message bits with poly bit0 set, init 0
        setcfg(5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0);
        do_init();
        feed_byte(8'hB5);
        check("parity_w1", crc, 32'h1);

        // Random well-formed messages against the whole-message reference
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, 32);
            msg_len = $urandom_range(1, 6);
            for (int k = 0; k < msg_len; k++) msg[k] = 8'($urandom);
            setcfg(5'(n - 1), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
            do_init();
            for (int k = 0; k < msg_len; k++) begin
                for (int bi = 0; bi < 8; bi++) begin
                    if ($urandom_range(0, 7) == 0) tick();
                    do_shift(msg[k], 3'(bi));
                end
            end
            check("rand_msg", crc, crc_of(msg_len, n, poly, init_value, xor_out, reflect_in, reflect_out));
        end

        // Unconstrained per-cycle traffic; the cycle model covers every edge
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 39) == 0);
            initialize = ($urandom_range(0, 9) == 0);
            shift      = ($urandom_range(0, 3) != 0);
            bit_index  = 3'($urandom);
            data       = 8'($urandom);
            if ($urandom_range(0, 15) == 0)
                setcfg(5'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
            tick();
        end
        rst = 1'b0; initialize = 1'b0; shift = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
